// File: rtl/cnt_seq_ctrl_pkg.sv
// Shared definitions for the step-counter sequencer.
// Holds the FSM state encodings and small state-decode helpers.
package cnt_ctrl_pkg;

    // FSM state width and encodings (also driven out on po_state)
    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_HOLD = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE = 2'd3;

    // A run is in progress (counting or paused)
    function automatic logic st_busy(input logic [ST_W-1:0] st);
        return (st == ST_RUN) || (st == ST_HOLD);
    endfunction

    // States in which a start pulse is accepted
    function automatic logic st_armable(input logic [ST_W-1:0] st);
        return (st == ST_IDLE) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/tick_div.sv
// Prescaler for the step counter: emits one tick every DIV enabled clocks.
// Ports: clk, rst (async, active-high), en (advance), clr (restart at 0),
//        tick (high in the enabled cycle whose edge completes a DIV period).
module tick_div #(
    parameter int DIV   = 5,
    parameter int DIV_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] pre_q;
    logic [DIV_W-1:0] pre_d;
    logic             at_last;

    assign at_last = (pre_q == LAST);

    // Tick is only meaningful while enabled; a frozen prescaler never ticks.
    assign tick = en && at_last;

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = at_last ? '0 : pre_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Sequencer for the step counter: start/pause/stop/reload with prescaled
// stepping and a one-clock completion pulse.
// Ports:
//   clk, rst            clock, async active-high reset
//   pi_start/pi_stop    start pulse (IDLE/DONE only), abort to IDLE
//   pi_pause            level, freezes the run while high
//   pi_dir/pi_auto      count direction, auto-reload; latched at start
//   pi_limit            terminal value, latched at start
//   po_cnt/po_busy      current count, RUN or HOLD
//   po_done/po_state    terminal pulse, FSM state
module cnt_seq_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int DIV   = 5,
    parameter int DIV_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pi_start,
    input  logic             pi_stop,
    input  logic             pi_pause,
    input  logic             pi_dir,
    input  logic             pi_auto,
    input  logic [CNT_W-1:0] pi_limit,
    output logic [CNT_W-1:0] po_cnt,
    output logic             po_busy,
    output logic             po_done,
    output logic [ST_W-1:0]  po_state
);

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] lim_q,   lim_d;
    logic             dir_q,   dir_d;
    logic             auto_q,  auto_d;
    logic             done_q,  done_d;
    logic             busy_q,  busy_d;

    logic             start_acc;
    logic             advance;
    logic             tick;
    logic [CNT_W-1:0] term;
    logic [CNT_W-1:0] reload;

    // Start only counts when armable and not overridden by stop.
    assign start_acc = pi_start && !pi_stop && st_armable(state_q);

    // The run advances in RUN, and also on the edge leaving HOLD, so a
    // pause of N clocks delays the next step by exactly N clocks.
    assign advance = !pi_stop && st_busy(state_q) && !pi_pause;

    assign term   = dir_q ? '0 : lim_q;
    assign reload = dir_q ? lim_q : '0;

    tick_div #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (advance),
        .clr  (pi_stop || start_acc),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        dir_d   = dir_q;
        auto_d  = auto_q;
        done_d  = 1'b0;

        if (pi_stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (pi_start) begin
                        state_d = ST_RUN;
                        lim_d   = pi_limit;
                        dir_d   = pi_dir;
                        auto_d  = pi_auto;
                        cnt_d   = pi_dir ? pi_limit : '0;
                    end
                end
                ST_RUN, ST_HOLD: begin
                    if (pi_pause) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_RUN;
                        if (tick) begin
                            if (cnt_q == term) begin
                                done_d = 1'b1;
                                if (auto_q) begin
                                    cnt_d = reload;
                                end else begin
                                    state_d = ST_DONE;
                                end
                            end else if (dir_q) begin
                                cnt_d = cnt_q - CNT_W'(1);
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = st_busy(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lim_q   <= '0;
            dir_q   <= 1'b0;
            auto_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
            auto_q  <= auto_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign po_cnt   = cnt_q;
    assign po_busy  = busy_q;
    assign po_done  = done_q;
    assign po_state = state_q;

endmodule
